// File: rtl/vga_frame_capture.sv
// vga_frame_capture: Avalon-ST video sink that grabs one full frame on request,
// nearest-neighbour downsamples it by SCALE, packs kept pixels to RGB444 and
// writes them into a STORED_WIDTH x STORED_HEIGHT buffer through a simple write port.
// Packet framing (SOP / EOP / frame length) is checked and errors are reported.
//
// Handshake: a beat is transferred on every clock edge where valid && ready.
// ready is held high from the first cycle after reset, so the source never stalls.
module vga_frame_capture #(
  parameter int STORED_WIDTH    = 160,
  parameter int STORED_HEIGHT   = 120,
  parameter int DISPLAY_WIDTH   = 640,
  parameter int DISPLAY_HEIGHT  = 480,
  parameter int SCALE           = 4,
  parameter int NUM_COLOUR_BITS = 12
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [29:0]                                        data,
  input  logic                                               startofpacket,
  input  logic                                               endofpacket,
  input  logic                                               valid,
  output logic                                               ready,
  input  logic                                               capture_start,
  output logic                                               capture_busy,
  output logic                                               capture_done,
  output logic                                               frame_error,
  output logic [7:0]                                         error_count,
  output logic                                               wr_en,
  output logic [$clog2(STORED_WIDTH*STORED_HEIGHT)-1:0]      wr_addr,
  output logic [NUM_COLOUR_BITS-1:0]                         wr_data,
  output logic [1:0]                                         fsm_state
);

  localparam int L          = $clog2(SCALE);
  localparam int NUM_PIXELS = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int XW         = $clog2(DISPLAY_WIDTH);
  localparam int YW         = $clog2(DISPLAY_HEIGHT);
  localparam int IW         = $clog2(NUM_PIXELS + 1);
  localparam int AW         = $clog2(STORED_WIDTH * STORED_HEIGHT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOP = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [XW-1:0]  x, x_nxt, px;
  logic [YW-1:0]  y, y_nxt, py;
  logic [IW-1:0]  idx, idx_nxt, pidx;
  logic           beat;
  logic           proc;      // current beat is consumed as a frame pixel
  logic           keep;      // processed pixel survives downsampling
  logic           err;       // framing error detected on this beat
  logic           done;      // frame completed cleanly on this beat
  logic           clr_err;   // accepted capture request clears the sticky error
  logic [AW-1:0]  addr_c;
  logic [NUM_COLOUR_BITS-1:0] pix_c;
  logic           unused_bits;

  assign beat         = valid & ready;
  assign capture_busy = (state != IDLE);
  assign fsm_state    = state;

  // Only the top 4 bits of each 10-bit channel are stored.
  assign pix_c       = NUM_COLOUR_BITS'({data[29:26], data[19:16], data[9:6]});
  assign unused_bits = ^{data[25:20], data[15:10], data[5:0]};

  assign keep   = proc && ((px & XW'(SCALE - 1)) == '0) && ((py & YW'(SCALE - 1)) == '0);
  assign addr_c = AW'(AW'(py >> L) * AW'(STORED_WIDTH)) + AW'(px >> L);

  // Next-state, pixel position and framing checks for the current beat.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    idx_nxt   = idx;
    proc      = 1'b0;
    px        = x;
    py        = y;
    pidx      = idx;
    err       = 1'b0;
    done      = 1'b0;
    clr_err   = 1'b0;

    case (state)
      IDLE: begin
        if (capture_start) begin
          state_nxt = WAIT_SOP;
          clr_err   = 1'b1;
        end
      end
      WAIT_SOP: begin
        if (beat && startofpacket) begin
          proc      = 1'b1;
          px        = '0;
          py        = '0;
          pidx      = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (beat) begin
          proc = 1'b1;
          // An unexpected SOP restarts the frame at pixel (0,0).
          if (startofpacket) begin
            px   = '0;
            py   = '0;
            pidx = '0;
            err  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (proc) begin
      if (px == XW'(DISPLAY_WIDTH - 1)) begin
        x_nxt = '0;
        y_nxt = py + 1'b1;
      end else begin
        x_nxt = px + 1'b1;
        y_nxt = py;
      end
      idx_nxt = pidx + 1'b1;

      if (pidx == IW'(NUM_PIXELS - 1)) begin
        if (endofpacket && !err) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          err       = 1'b1;
          state_nxt = WAIT_SOP;
        end
      end else if (endofpacket) begin
        err       = 1'b1;
        state_nxt = WAIT_SOP;
      end

      if (state_nxt != CAPTURE) begin
        x_nxt   = '0;
        y_nxt   = '0;
        idx_nxt = '0;
      end
    end
  end

  // State and frame-position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      idx   <= idx_nxt;
    end
  end

  // Registered outputs: ready, buffer write port, completion and error reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready        <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      capture_done <= 1'b0;
      frame_error  <= 1'b0;
      error_count  <= '0;
    end else begin
      ready        <= 1'b1;
      wr_en        <= keep;
      capture_done <= done;
      if (keep) begin
        wr_addr <= addr_c;
        wr_data <= pix_c;
      end
      if (err) begin
        frame_error <= 1'b1;
      end else if (clr_err) begin
        frame_error <= 1'b0;
      end
      if (err && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

endmodule
